// File: rtl/npc_arb_pkg.sv
// Shared types for the IFU/LSU memory port arbiter: FSM state and owner encodings.
package npc_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant picker for the memory port arbiter.
// Fixed LSU priority by default; ARB_ROUND_ROBIN_EN alternates between simultaneous requesters.
module arb_pick
    import npc_arb_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_e last_served,
    output owner_e grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
            grant = (last_served == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (lsu_valid) begin
            grant = OWN_LSU;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_served;

    // IFU only wins when the LSU is silent.
    always_comb begin
        grant = OWN_IFU;
        if (lsu_valid) begin
            grant = OWN_LSU;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto one memory port, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN swaps fixed LSU priority for last-served round-robin.
module mem_port_arbiter
    import npc_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    input  logic                ifu_flush,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    state_e state_q;
    owner_e owner_q;
    logic   drop_q;
    owner_e grant;
    owner_e last_served;
    logic   flush_hit;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q;
    assign last_served = last_q;
`else
    assign last_served = OWN_LSU;
`endif

    arb_pick u_pick (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .last_served (last_served),
        .grant       (grant)
    );

    assign flush_hit = ifu_flush && (owner_q == OWN_IFU);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= OWN_IFU;
            drop_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= OWN_LSU;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ifu_req_valid || lsu_req_valid) begin
                        owner_q <= grant;
                        state_q <= StReq;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q  <= grant;
`endif
                    end
                end
                StReq: begin
                    if (flush_hit) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (mem_rsp_valid) begin
                        state_q <= StIdle;
                        drop_q  <= 1'b0;
                    end else if (flush_hit) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic in_req;
    logic rsp_fire;

    // Reset gates every handshake output so nothing leaks while rst is high.
    assign in_req   = !rst && (state_q == StReq);
    assign rsp_fire = !rst && (state_q == StWait) && mem_rsp_valid;

    always_comb begin
        mem_req_valid = in_req;
        mem_addr      = '0;
        mem_wen       = 1'b0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        if (in_req) begin
            if (owner_q == OWN_LSU) begin
                mem_addr  = lsu_addr;
                mem_wen   = lsu_wen;
                mem_wdata = lsu_wdata;
                mem_wmask = lsu_wmask;
            end else begin
                mem_addr  = ifu_addr;
            end
        end
    end

    assign ifu_req_ready = in_req && (owner_q == OWN_IFU) && mem_req_ready;
    assign lsu_req_ready = in_req && (owner_q == OWN_LSU) && mem_req_ready;

    // A flush landing in the response cycle itself also kills that response.
    assign ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU) && !drop_q && !ifu_flush;
    assign lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);

    assign ifu_rsp_data = mem_rsp_data;
    assign lsu_rsp_data = mem_rsp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = DW / 8;
    localparam int          NumCycles = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_flush, ifu_rsp_valid;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rsp_data;
    logic [SW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rsp_data;
    logic [SW-1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_flush     (ifu_flush),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Reference transaction: at most one open, owner 1 = LSU, 0 = IFU.
    bit m_open, m_sent, m_drop, m_owner, m_last;
    int n_ifu_rsp, n_lsu_rsp, n_exp_ifu, n_exp_lsu;

    function automatic bit pick(input bit iv, input bit lv, input bit last);
`ifdef ARB_ROUND_ROBIN_EN
        if (iv && lv) return !last;
`endif
        return lv;
    endfunction

    bit e_mreq, e_irdy, e_lrdy, e_irsp, e_lrsp;

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = '0; ifu_flush = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
        m_open = 0; m_sent = 0; m_drop = 0; m_owner = 0; m_last = 1;
        n_ifu_rsp = 0; n_lsu_rsp = 0; n_exp_ifu = 0; n_exp_lsu = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NumCycles; i++) begin
            // Drive this cycle's inputs; requesters hold their fields until accepted.
            rst = (i < 3) ? 1'b1 : ($urandom_range(0, 199) == 0);
            if (i == 3) begin
                ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
                lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
                lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
            end else if (i > 3) begin
                if (!ifu_req_valid) begin
                    ifu_req_valid = ($urandom_range(0, 2) == 0);
                    ifu_addr      = $urandom;
                end
                if (!lsu_req_valid) begin
                    lsu_req_valid = ($urandom_range(0, 2) == 0);
                    lsu_addr      = $urandom;
                    lsu_wen       = $urandom_range(0, 1);
                    lsu_wdata     = {$urandom, $urandom};
                    lsu_wmask     = 8'($urandom_range(0, 255));
                end
            end
            ifu_flush     = (i > 3) && ($urandom_range(0, 7) == 0);
            mem_req_ready = ($urandom_range(0, 3) != 0);
            mem_rsp_valid = ($urandom_range(0, 2) == 0);
            mem_rsp_data  = {$urandom, $urandom};

            @(negedge clk);
            e_mreq = !rst && m_open && !m_sent;
            e_irdy = e_mreq && !m_owner && mem_req_ready;
            e_lrdy = e_mreq && m_owner && mem_req_ready;
            e_irsp = !rst && m_open && m_sent && mem_rsp_valid && !m_owner && !m_drop && !ifu_flush;
            e_lrsp = !rst && m_open && m_sent && mem_rsp_valid && m_owner;
            check("mem_req_valid", 64'(mem_req_valid), 64'(e_mreq));
            check("mem_addr", 64'(mem_addr), !e_mreq ? 64'd0 : (m_owner ? 64'(lsu_addr) : 64'(ifu_addr)));
            check("mem_wen", 64'(mem_wen), 64'(e_mreq && m_owner && lsu_wen));
            check("mem_wdata", mem_wdata, (e_mreq && m_owner) ? lsu_wdata : 64'd0);
            check("mem_wmask", 64'(mem_wmask), (e_mreq && m_owner) ? 64'(lsu_wmask) : 64'd0);
            check("ifu_req_ready", 64'(ifu_req_ready), 64'(e_irdy));
            check("lsu_req_ready", 64'(lsu_req_ready), 64'(e_lrdy));
            check("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(e_irsp));
            check("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(e_lrsp));
            if (e_irsp) check("ifu_rsp_data", ifu_rsp_data, mem_rsp_data);
            if (e_lrsp) check("lsu_rsp_data", lsu_rsp_data, mem_rsp_data);
            n_ifu_rsp += int'(ifu_rsp_valid);
            n_lsu_rsp += int'(lsu_rsp_valid);
            n_exp_ifu += int'(e_irsp);
            n_exp_lsu += int'(e_lrsp);

            @(posedge clk);
            if (rst) begin
                m_open = 0; m_sent = 0; m_drop = 0; m_owner = 0; m_last = 1;
            end else if (!m_open) begin
                if (ifu_req_valid || lsu_req_valid) begin
                    m_owner = pick(ifu_req_valid, lsu_req_valid, m_last);
                    m_last  = m_owner;
                    m_open  = 1;
                    m_sent  = 0;
                end
            end else if (!m_sent) begin
                if (ifu_flush && !m_owner) m_drop = 1;
                if (mem_req_ready) m_sent = 1;
            end else if (mem_rsp_valid) begin
                m_open = 0;
                m_drop = 0;
            end else if (ifu_flush && !m_owner) begin
                m_drop = 1;
            end
            #1;
            if (e_irdy) ifu_req_valid = 0;
            if (e_lrdy) lsu_req_valid = 0;
        end
        check("ifu_rsp_count", 64'(n_ifu_rsp), 64'(n_exp_ifu));
        check("lsu_rsp_count", 64'(n_lsu_rsp), 64'(n_exp_lsu));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single core memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Each requester uses a valid/ready request channel and gets a valid-only response channel. The block serialises the two into one outstanding transaction on the memory side. It sits between IFU/LSU and the memory/bus bridge, upstream of the LSU read-data path that feeds the MEM/WB stage register.

## Interface
- Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- Ports (all ports are sampled and driven in the `clk` domain; reset is synchronous, active-high, named `rst`):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU read request handshake
- ifu_addr  in  ADDR_W  fetch address
- ifu_flush  in  1  pulse: discard the IFU response in flight
- ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse
- ifu_rsp_data  out  DATA_W  fetch data
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W  load/store address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_rsp_valid  out  1  load data valid, or store-complete pulse
- lsu_rsp_data  out  DATA_W  load data
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  request fields
- mem_rsp_valid  in  1  memory response pulse
- mem_rsp_data  in  DATA_W  memory response data

## Operation
- FSM states: IDLE, REQ, WAIT. An `owner` register holds IFU or LSU. A `drop` flag suppresses the IFU response after a flush.
- IDLE:
  - If any `*_req_valid` is high, latch `owner` from the picker and go to REQ.
  - No ready is asserted in IDLE.
- REQ:
  - `mem_req_valid`=1. The `mem_*` fields are muxed from the owner's inputs; IFU requests force `mem_wen`=0 and `mem_wmask`=0.
  - The owner's `*_req_ready` = `mem_req_ready` (combinational). Requesters hold their fields stable until ready.
  - When `mem_req_ready` is high, go to WAIT.
- WAIT:
  - On `mem_rsp_valid`, pulse the owner's `*_rsp_valid`, unless owner=IFU and `drop`=1. Then go to IDLE and clear `drop`.
- Picker, default: fixed LSU priority. IFU is granted only when `lsu_req_valid`=0.
- Flush: `ifu_flush` in REQ or WAIT while owner=IFU sets `drop`.
  - A request already in REQ still completes its memory handshake; it is never withdrawn.
  - `ifu_flush` in IDLE, or while owner=LSU, has no effect.
- Outside REQ, `mem_req_valid`=0 and `mem_addr`/`mem_wen`/`mem_wdata`/`mem_wmask`=0.
- `mem_rsp_valid` outside WAIT is ignored.
- `*_rsp_data` = `mem_rsp_data` pass-through; its value is meaningful only with the matching `*_rsp_valid`.

## Timing
- Reset: state=IDLE, owner=IFU, `drop`=0, last-served=LSU.
- All valid and ready outputs are 0 during and after reset.
- `mem_*` request fields are 0 during and after reset.
- Reset mid-transaction: return to IDLE. A late `mem_rsp_valid` is dropped.
- Request-to-memory latency: `req_valid` seen in cycle N → `mem_req_valid` in N+1.
- Response path: `mem_rsp_valid` → `*_rsp_valid` in the same cycle, with zero added latency.
- Minimum occupancy is 3 cycles per transaction (IDLE, REQ, WAIT). The next grant is evaluated in the IDLE cycle after the response.
- A new request arriving during WAIT waits; it is not granted until the IDLE cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: a last-served register updates on each grant. If both requesters are valid in IDLE, grant the one not served last. A single requester is always granted.
  - Undefined: fixed LSU priority, with no last-served register.

## Structure
- Shared package `npc_arb_pkg`: state encoding (IDLE/REQ/WAIT) and owner constants (`OWN_IFU`=0, `OWN_LSU`=1).
- One sub-module, `arb_pick`, is combinational. Inputs: two valids plus last-served. Output: grant owner. The round-robin logic lives inside `arb_pick` under the macro.

## Test plan
- Single IFU read, addr 0x8000_0000, `mem_req_ready`=1, response 0x1122334455667788 two cycles later → `mem_req_valid` in cycle 1, `ifu_rsp_valid` pulse carrying 0x1122334455667788, `lsu_rsp_valid` stays 0.
- LSU store, addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0x0F → `mem_wen`=1 and `mem_wmask`=0x0F; `lsu_rsp_valid` pulses on `mem_rsp_valid`.
- Both request in the same IDLE cycle:
  - Default build: LSU granted first, IFU second.
  - With `ARB_ROUND_ROBIN_EN`, last-served=LSU: IFU granted first.
- `mem_req_ready` held 0 for 5 cycles → `mem_req_valid` and fields stable throughout, `ifu_req_ready`=0, then a single handshake.
- IFU owner in WAIT, `ifu_flush`=1, response 0xAA arrives → `ifu_rsp_valid` stays 0; FSM returns to IDLE.
- `rst` asserted in WAIT, then `mem_rsp_valid` arrives one cycle after reset deasserts → no `*_rsp_valid` pulse, and all outputs are 0.
